// File: rtl/individual_fitness_driver.sv
// rtl/individual_fitness_driver.sv - drives test vectors into an evolved individual and scores its results
module individual_fitness_driver #(
    parameter int W      = 16,
    parameter int SETTLE = 1,
    parameter int CW     = 8,
    parameter int FW     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   num_cases,
    input  logic            vec_valid,
    output logic            vec_ready,
    input  logic [4*W-1:0]  vec_operands,
    input  logic [4*W-1:0]  vec_expected,
    output logic [W-1:0]    a1,
    output logic [W-1:0]    a0,
    output logic [W-1:0]    b1,
    output logic [W-1:0]    b0,
    input  logic [W-1:0]    y3,
    input  logic [W-1:0]    y2,
    input  logic [W-1:0]    y1,
    input  logic [W-1:0]    y0,
    output logic            busy,
    output logic            done,
    output logic [FW-1:0]   fitness,
    output logic [CW-1:0]   hits
);

    localparam int EW  = $clog2(4 * W + 1);
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETTLE,
        ST_SCORE,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   ncases;
    logic [CW-1:0]   case_cnt;
    logic [CW-1:0]   case_cnt_inc;
    logic [SCW-1:0]  settle_cnt;
    logic [4*W-1:0]  exp_q;
    logic [4*W-1:0]  cap_q;
    logic [EW-1:0]   err;
    logic [FW:0]     fit_sum;

    function automatic logic [EW-1:0] popcount(input logic [W-1:0] v);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + {{(EW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign err = popcount(cap_q[4*W-1:3*W] ^ exp_q[4*W-1:3*W])
               + popcount(cap_q[3*W-1:2*W] ^ exp_q[3*W-1:2*W])
               + popcount(cap_q[2*W-1:W]   ^ exp_q[2*W-1:W])
               + popcount(cap_q[W-1:0]     ^ exp_q[W-1:0]);

    // One spare bit catches the carry that triggers saturation.
    assign fit_sum      = {1'b0, fitness} + {{(FW+1-EW){1'b0}}, err};
    assign case_cnt_inc = case_cnt + {{(CW-1){1'b0}}, 1'b1};

    assign vec_ready = (state == ST_FETCH);
    assign done      = (state == ST_DONE);
    assign busy      = (state == ST_FETCH) || (state == ST_SETTLE) || (state == ST_SCORE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = (num_cases == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH:  if (vec_valid) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_SCORE;
            ST_SCORE:  state_nxt = (case_cnt_inc == ncases) ? ST_DONE : ST_FETCH;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncases     <= '0;
            case_cnt   <= '0;
            settle_cnt <= '0;
            exp_q      <= '0;
            cap_q      <= '0;
            fitness    <= '0;
            hits       <= '0;
            a1         <= '0;
            a0         <= '0;
            b1         <= '0;
            b0         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ncases   <= num_cases;
                        case_cnt <= '0;
                        fitness  <= '0;
                        hits     <= '0;
                    end
                end
                ST_FETCH: begin
                    if (vec_valid) begin
                        {a1, a0, b1, b0} <= vec_operands;
                        exp_q            <= vec_expected;
                        settle_cnt       <= SCW'(SETTLE - 1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        cap_q <= {y3, y2, y1, y0};
                    end else begin
                        settle_cnt <= settle_cnt - {{(SCW-1){1'b0}}, 1'b1};
                    end
                end
                ST_SCORE: begin
                    fitness  <= fit_sum[FW] ? {FW{1'b1}} : fit_sum[FW-1:0];
                    if (err == '0 && hits != {CW{1'b1}}) begin
                        hits <= hits + {{(CW-1){1'b0}}, 1'b1};
                    end
                    case_cnt <= case_cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_individual_fitness_driver.sv
// tb/tb_individual_fitness_driver.sv - randomized self-checking bench for individual_fitness_driver
module tb_individual_fitness_driver;

    localparam int W      = 16;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_cases = '0;
    logic        vec_valid = 1'b0;
    logic [63:0] vec_operands = '0;
    logic [63:0] vec_expected = '0;
    bit          mode = 1'b0;

    logic        vr_w, busy_w, done_w, vr_n, busy_n, done_n;
    logic [15:0] a1_w, a0_w, b1_w, b0_w, a1_n, a0_n, b1_n, b0_n;
    logic [15:0] y3_w, y2_w, y1_w, y0_w, y3_n, y2_n, y1_n, y0_n;
    logic [31:0] fit_w;
    logic [7:0]  fit_n, hits_w, hits_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [63:0] ops_tab [8];
    logic [63:0] exp_tab [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Candidate individual: mode 0 is the reference circuit, mode 1 has every output tied low.
    function automatic logic [63:0] indiv(input logic [63:0] ops, input bit md);
        logic [15:0] a1v, b1v;
        a1v = ops[63:48];
        b1v = ops[31:16];
        if (md) return 64'd0;
        return {a1v & b1v, ~b1v, a1v & b1v, ~a1v};
    endfunction

    assign {y3_w, y2_w, y1_w, y0_w} = indiv({a1_w, a0_w, b1_w, b0_w}, mode);
    assign {y3_n, y2_n, y1_n, y0_n} = indiv({a1_n, a0_n, b1_n, b0_n}, mode);

    individual_fitness_driver #(.W(W), .SETTLE(SETTLE), .CW(8), .FW(32)) dut_w (
        .clk(clk), .rst(rst), .start(start), .num_cases(num_cases),
        .vec_valid(vec_valid), .vec_ready(vr_w),
        .vec_operands(vec_operands), .vec_expected(vec_expected),
        .a1(a1_w), .a0(a0_w), .b1(b1_w), .b0(b0_w),
        .y3(y3_w), .y2(y2_w), .y1(y1_w), .y0(y0_w),
        .busy(busy_w), .done(done_w), .fitness(fit_w), .hits(hits_w)
    );

    individual_fitness_driver #(.W(W), .SETTLE(SETTLE), .CW(8), .FW(8)) dut_n (
        .clk(clk), .rst(rst), .start(start), .num_cases(num_cases),
        .vec_valid(vec_valid), .vec_ready(vr_n),
        .vec_operands(vec_operands), .vec_expected(vec_expected),
        .a1(a1_n), .a0(a0_n), .b1(b1_n), .b0(b0_n),
        .y3(y3_n), .y2(y2_n), .y1(y1_n), .y0(y0_n),
        .busy(busy_n), .done(done_n), .fitness(fit_n), .hits(hits_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Schedule-based reference: a run is a list of cases, each occupying a fetch wait,
    // SETTLE cycles and one scoring cycle, followed by a single done cycle.
    bit          m_idle = 1'b1, m_ready = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [63:0] m_ops = '0;
    longint      m_total = 0;
    int          m_hits = 0, m_cnt = 0, m_n = 0, m_err = 0, m_score_at = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle = 1'b1; m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_ops = '0; m_total = 0; m_hits = 0; m_cnt = 0; m_n = 0; m_score_at = -1;
        end else if (m_done) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (start) begin
                m_idle = 1'b0; m_n = num_cases; m_total = 0; m_hits = 0; m_cnt = 0;
                if (num_cases == 0) m_done = 1'b1;
                else begin m_busy = 1'b1; m_ready = 1'b1; end
            end
        end else if (m_ready) begin
            if (vec_valid) begin
                m_ops      = vec_operands;
                m_err      = $countones(indiv(vec_operands, mode) ^ vec_expected);
                m_score_at = cyc + SETTLE + 1;
                m_ready    = 1'b0;
            end
        end else if (cyc == m_score_at) begin
            m_total += m_err;
            if (m_err == 0 && m_hits < 255) m_hits++;
            m_cnt++;
            if (m_cnt == m_n) begin m_done = 1'b1; m_busy = 1'b0; end
            else m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("vec_ready_w", vr_w, m_ready);
        chk("busy_w", busy_w, m_busy);
        chk("done_w", done_w, m_done);
        chk("operands_w", {a1_w, a0_w, b1_w, b0_w}, m_ops);
        chk("fitness_w", fit_w, (m_total > 64'hFFFFFFFF) ? 64'hFFFFFFFF : 64'(m_total));
        chk("hits_w", hits_w, m_hits);
        chk("vec_ready_n", vr_n, m_ready);
        chk("done_n", done_n, m_done);
        chk("operands_n", {a1_n, a0_n, b1_n, b0_n}, m_ops);
        chk("fitness_n", fit_n, (m_total > 255) ? 64'd255 : 64'(m_total));
        chk("hits_n", hits_n, m_hits);
        if (done_w) done_cnt++;
    end

    // Runs n cases from ops_tab/exp_tab; returns start-to-done cycles, or -1 when aborted by reset.
    task automatic run(input int n, input bit stall, input bit ign_start, input int abort_at, output int dur);
        int t0, guard;
        num_cases = 8'(n);
        start     = 1'b1;
        t0        = cyc;
        done_cnt  = 0;
        dur       = -1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (stall && i > 0) begin
                vec_valid = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            vec_operands = ops_tab[i];
            vec_expected = exp_tab[i];
            vec_valid    = 1'b1;
            guard = 0;
            while (!vr_w && guard < 50) begin @(posedge clk); #1; guard++; end
            if (guard >= 50) begin timeout("handshake"); vec_valid = 1'b0; return; end
            @(posedge clk); #1;
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                vec_valid = 1'b0;
                return;
            end
            if (ign_start && i == 0) begin
                start = 1'b1; num_cases = 8'd9;
                @(posedge clk); #1;
                start = 1'b0; num_cases = 8'(n);
            end
        end
        vec_valid = 1'b0;
        guard = 0;
        while (!done_w && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) timeout("done");
        else dur = cyc - t0;
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] sparse64();
        return {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
    endfunction

    task automatic fill(input int n, input bit md, input bit noisy);
        for (int i = 0; i < n; i++) begin
            ops_tab[i] = rand64();
            exp_tab[i] = indiv(ops_tab[i], md) ^ (noisy ? sparse64() : 64'd0);
        end
    endtask

    initial begin
        int     dur, n;
        bit     st;
        longint saved_total;
        int     saved_hits;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_fitness", fit_w, 64'd0);
        chk("reset_operands", {a1_w, a0_w, b1_w, b0_w}, 64'd0);

        mode = 1'b0;
        fill(4, 1'b0, 1'b1);
        run(4, 1'b0, 1'b0, 1, dur);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 64'd0);
        chk("abort_busy", busy_w, 64'd0);
        chk("abort_operands", {a1_w, a0_w, b1_w, b0_w}, 64'd0);

        fill(3, 1'b0, 1'b0);
        ops_tab[0] = {16'hFFFF, 16'(rand64()), 16'h0000, 16'(rand64())};
        exp_tab[0] = indiv(ops_tab[0], 1'b0);
        run(3, 1'b0, 1'b0, -1, dur);
        chk("perfect_fitness", fit_w, 64'd0);
        chk("perfect_hits", hits_w, 64'd3);
        chk("perfect_cycles", 64'(dur), 64'd10);
        chk("perfect_done_pulses", done_cnt, 64'd1);

        mode = 1'b1;
        ops_tab[0] = rand64();
        exp_tab[0] = {16'hFFFF, 16'h00FF, 16'h000F, 16'h0001};
        run(1, 1'b0, 1'b0, -1, dur);
        chk("score_fitness", fit_w, 64'd29);
        chk("score_hits", hits_w, 64'd0);

        run(0, 1'b0, 1'b0, -1, dur);
        chk("zero_cases_cycles", 64'(dur), 64'd1);
        chk("zero_cases_fitness", fit_w, 64'd0);

        for (int i = 0; i < 5; i++) begin
            ops_tab[i] = rand64();
            exp_tab[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        run(5, 1'b0, 1'b0, -1, dur);
        chk("sat_fitness_narrow", fit_n, 64'd255);
        chk("sat_fitness_wide", fit_w, 64'd320);

        mode = 1'b0;
        fill(4, 1'b0, 1'b1);
        run(4, 1'b0, 1'b0, -1, dur);
        saved_total = m_total;
        saved_hits  = m_hits;
        run(4, 1'b1, 1'b0, -1, dur);
        chk("stall_fitness", fit_w, 64'(saved_total));
        chk("stall_hits", hits_w, saved_hits);

        fill(3, 1'b0, 1'b1);
        run(3, 1'b0, 1'b1, -1, dur);
        chk("ign_start_cycles", 64'(dur), 64'd10);
        chk("ign_start_done_pulses", done_cnt, 64'd1);

        for (int r = 0; r < 8; r++) begin
            n    = $urandom_range(1, 6);
            mode = 1'($urandom_range(0, 1));
            st   = 1'($urandom_range(0, 1));
            fill(n, mode, 1'($urandom_range(0, 1)));
            run(n, st, 1'b0, -1, dur);
            if (!st) chk("rand_cycles", 64'(dur), 64'(n * (SETTLE + 2) + 1));
            chk("rand_done_pulses", done_cnt, 64'd1);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
